// File: rtl/store_unit_pkg.sv
// Store-path encodings and the queue entry format shared by store_unit and sq_fifo.
// Store encodings mirror the store-control values in processor_defines.sv.
package store_unit_pkg;

  localparam logic [2:0] ST_SB      = 3'b000;
  localparam logic [2:0] ST_SH      = 3'b001;
  localparam logic [2:0] ST_SW      = 3'b010;
  localparam logic [2:0] ST_STR_NOP = 3'b111;

  localparam int BE_W = 4;

  typedef struct packed {
    logic [29:0]     addr_word;
    logic [31:0]     wdata;
    logic [BE_W-1:0] be;
  } sq_entry_t;

  // Lanes are formatted once, at enqueue, so the write port is a straight register read.
  function automatic sq_entry_t format_store(input logic [2:0]  ctrl,
                                             input logic [31:0] ea,
                                             input logic [31:0] d);
    sq_entry_t e;
    e.addr_word = ea[31:2];
    e.wdata     = d;
    e.be        = 4'b1111;
    case (ctrl)
      ST_SB: begin
        e.wdata = {4{d[7:0]}};
        e.be    = 4'b0001 << ea[1:0];
      end
      ST_SH: begin
        e.wdata = {2{d[15:0]}};
        e.be    = ea[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/store_unit_sq_fifo.sv
// In-order store queue: synchronous FIFO of formatted store entries.
// Pointers wrap naturally; the extra count bit distinguishes full from empty.
module sq_fifo
  import store_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  sq_entry_t        push_data,
  input  logic             pop,
  output sq_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  sq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once the pointers cover it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/store_unit.sv
// Execute-side store path: effective address, alignment check, lane formatting,
// and an in-order queue draining to the data-memory write port over req/gnt.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [2:0]        st_control,
  input  logic [ADDR_W-1:0] st_base,
  input  logic [11:0]       st_imm,
  input  logic [DATA_W-1:0] st_data,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] misalign_addr,
  output logic              sq_empty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] ea;
  logic              accept;
  logic              is_store;
  logic              aligned;
  logic              push;
  sq_entry_t         push_entry;
  sq_entry_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  count;

  assign ea       = st_base + {{(ADDR_W-12){st_imm[11]}}, st_imm};
  assign st_ready = !fifo_full && !reset;
  assign accept   = st_valid && st_ready;

  // STR_NOP and undefined encodings are accepted but never enqueued or flagged.
  always_comb begin
    is_store = 1'b0;
    aligned  = 1'b1;
    case (st_control)
      ST_SB: is_store = 1'b1;
      ST_SH: begin
        is_store = 1'b1;
        aligned  = !ea[0];
      end
      ST_SW: begin
        is_store = 1'b1;
        aligned  = (ea[1:0] == 2'b00);
      end
      default: ;
    endcase
  end

  assign push       = accept && is_store && aligned;
  assign push_entry = format_store(st_control, ea, st_data);

  sq_fifo #(.DEPTH(DEPTH)) u_sq_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (mem_req && mem_gnt),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign mem_req   = !fifo_empty;
  assign mem_addr  = mem_req ? {head.addr_word, 2'b00} : '0;
  assign mem_wdata = mem_req ? head.wdata : '0;
  assign mem_be    = mem_req ? head.be : '0;
  assign sq_empty  = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_err <= accept && is_store && !aligned;
      if (accept && is_store && !aligned) misalign_addr <= ea;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_store_unit;
  import store_unit_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_control;
  logic [31:0] st_base;
  logic [11:0] st_imm;
  logic [31:0] st_data;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign_err;
  logic [31:0] misalign_addr;
  logic        sq_empty;

  int n_compared   = 0;
  int n_mismatched = 0;

  store_unit #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_control    (st_control),
    .st_base       (st_base),
    .st_imm        (st_imm),
    .st_data       (st_data),
    .mem_req       (mem_req),
    .mem_gnt       (mem_gnt),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .misalign_err  (misalign_err),
    .misalign_addr (misalign_addr),
    .sq_empty      (sq_empty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a plain queue of expected memory writes plus the error registers.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } wr_t;

  wr_t         mq[$];
  logic        exp_err   = 1'b0;
  logic [31:0] exp_maddr = 32'h0;
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    automatic int          n = mq.size();
    automatic bit          do_pop;
    automatic bit          take;
    automatic int          imm_val;
    automatic logic [31:0] ea;
    automatic wr_t         w;
    automatic bit          bad;
    automatic bit          store;
    model_live = 1'b1;
    if (reset) begin
      mq.delete();
      exp_err   = 1'b0;
      exp_maddr = 32'h0;
    end else begin
      do_pop  = (n > 0) && mem_gnt;
      take    = st_valid && (n < DEPTH);
      exp_err = 1'b0;
      bad     = 1'b0;
      store   = 1'b0;
      imm_val = (st_imm >= 12'd2048) ? int'(st_imm) - 4096 : int'(st_imm);
      ea      = st_base + imm_val;
      w.addr  = ea - (ea % 4);
      if (take) begin
        if (st_control == ST_SB) begin
          store   = 1'b1;
          w.be    = 4'(1 << (ea % 4));
          w.wdata = {24'h0, st_data[7:0]} * 32'h01010101;
        end else if (st_control == ST_SH) begin
          store   = 1'b1;
          bad     = (ea % 2) != 0;
          w.be    = ((ea % 4) >= 2) ? 4'hC : 4'h3;
          w.wdata = {16'h0, st_data[15:0]} * 32'h00010001;
        end else if (st_control == ST_SW) begin
          store   = 1'b1;
          bad     = (ea % 4) != 0;
          w.be    = 4'hF;
          w.wdata = st_data;
        end
      end
      if (do_pop) void'(mq.pop_front());
      if (store && bad) begin
        exp_err   = 1'b1;
        exp_maddr = ea;
      end else if (store) begin
        mq.push_back(w);
      end
    end
  end

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("mem_req", 32'(mem_req), 32'(mq.size() > 0));
      checkOutput("mem_addr", mem_addr, (mq.size() > 0) ? mq[0].addr : 32'h0);
      checkOutput("mem_wdata", mem_wdata, (mq.size() > 0) ? mq[0].wdata : 32'h0);
      checkOutput("mem_be", 32'(mem_be), (mq.size() > 0) ? 32'(mq[0].be) : 32'h0);
      checkOutput("misalign_err", 32'(misalign_err), 32'(exp_err));
      checkOutput("misalign_addr", misalign_addr, exp_maddr);
      checkOutput("sq_empty", 32'(sq_empty), 32'(mq.size() == 0));
      checkOutput("st_ready", 32'(st_ready), 32'((mq.size() < DEPTH) && !reset));
    end
  end

  task automatic applyStimulus(input logic v, input logic [2:0] ctrl, input logic [31:0] base,
                               input logic [11:0] imm, input logic [31:0] d, input logic gnt);
    st_valid   = v;
    st_control = ctrl;
    st_base    = base;
    st_imm     = imm;
    st_data    = d;
    mem_gnt    = gnt;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, ST_STR_NOP, 32'h0, 12'h0, 32'h0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("reset mem_req", 32'(mem_req), 32'h0);
    checkOutput("reset sq_empty", 32'(sq_empty), 32'h1);
    checkOutput("reset misalign_addr", misalign_addr, 32'h0);
    reset = 1'b0;

    // SB: byte lane 3 of word 0x1000
    applyStimulus(1'b1, ST_SB, 32'h1000, 12'h003, 32'hAABBCCDD, 1'b0);
    stepCycle();
    checkOutput("t1 mem_req", 32'(mem_req), 32'h1);
    checkOutput("t1 mem_addr", mem_addr, 32'h1000);
    checkOutput("t1 mem_be", 32'(mem_be), 32'h8);
    checkOutput("t1 mem_wdata", mem_wdata, 32'hDDDDDDDD);
    applyStimulus(1'b0, ST_STR_NOP, 32'h0, 12'h0, 32'h0, 1'b1);
    stepCycle();
    checkOutput("t1 drained", 32'(mem_req), 32'h0);

    // SH with negative immediate
    applyStimulus(1'b1, ST_SH, 32'h2000, 12'hFFE, 32'h00001234, 1'b0);
    stepCycle();
    checkOutput("t2 mem_addr", mem_addr, 32'h1FFC);
    checkOutput("t2 mem_be", 32'(mem_be), 32'hC);
    checkOutput("t2 mem_wdata", mem_wdata, 32'h12341234);
    applyStimulus(1'b0, ST_STR_NOP, 32'h0, 12'h0, 32'h0, 1'b1);
    stepCycle();

    // Misaligned SW
    applyStimulus(1'b1, ST_SW, 32'h3001, 12'h000, 32'h55555555, 1'b0);
    stepCycle();
    checkOutput("t3 misalign_err", 32'(misalign_err), 32'h1);
    checkOutput("t3 misalign_addr", misalign_addr, 32'h3001);
    checkOutput("t3 mem_req", 32'(mem_req), 32'h0);
    checkOutput("t3 sq_empty", 32'(sq_empty), 32'h1);
    applyStimulus(1'b0, ST_STR_NOP, 32'h0, 12'h0, 32'h0, 1'b0);
    stepCycle();
    checkOutput("t3 err pulse", 32'(misalign_err), 32'h0);
    checkOutput("t3 addr held", misalign_addr, 32'h3001);

    // Fill with grant low, then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, ST_SW, 32'h100 + 32'(4 * i), 12'h0, 32'hC0DE0000 + 32'(i), 1'b0);
      stepCycle();
    end
    checkOutput("t4 full ready", 32'(st_ready), 32'h0);
    applyStimulus(1'b0, ST_STR_NOP, 32'h0, 12'h0, 32'h0, 1'b0);
    stepCycle();
    checkOutput("t4 head held", mem_addr, 32'h100);
    applyStimulus(1'b1, ST_SW, 32'h200, 12'h0, 32'hBAD0BAD0, 1'b1);
    stepCycle();
    checkOutput("t4 ready after pop", 32'(st_ready), 32'h1);
    checkOutput("t4 second head", mem_addr, 32'h104);
    applyStimulus(1'b0, ST_STR_NOP, 32'h0, 12'h0, 32'h0, 1'b1);
    for (int i = 2; i < DEPTH; i++) begin
      checkOutput("t4 order", mem_wdata, 32'hC0DE0000 + 32'(i - 1));
      stepCycle();
    end
    stepCycle();
    checkOutput("t4 no extra write", 32'(mem_req), 32'h0);

    // Push and grant every cycle
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, ST_SW, 32'h400 + 32'(4 * i), 12'h0, 32'(i), 1'b1);
      stepCycle();
      checkOutput("t5 streaming head", mem_addr, 32'h400 + 32'(4 * i));
    end
    applyStimulus(1'b0, ST_STR_NOP, 32'h0, 12'h0, 32'h0, 1'b1);
    stepCycle();
    checkOutput("t5 drained", 32'(sq_empty), 32'h1);

    // Reset mid-request drops queued entries
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, ST_SW, 32'h800 + 32'(4 * i), 12'h0, 32'(i), 1'b0);
      stepCycle();
    end
    applyStimulus(1'b0, ST_STR_NOP, 32'h0, 12'h0, 32'h0, 1'b0);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    #1;
    checkOutput("t6 mem_req", 32'(mem_req), 32'h0);
    checkOutput("t6 sq_empty", 32'(sq_empty), 32'h1);
    checkOutput("t6 st_ready", 32'(st_ready), 32'h1);
    applyStimulus(1'b1, ST_STR_NOP, 32'h900, 12'h0, 32'h1, 1'b1);
    stepCycle();
    checkOutput("t6 nop no write", 32'(mem_req), 32'h0);
    checkOutput("t6 nop no error", 32'(misalign_err), 32'h0);

    // Randomized traffic; the compare process checks every cycle
    for (int c = 0; c < 3000; c++) begin
      automatic int          r = $urandom_range(0, 9);
      automatic logic [2:0]  ctrl;
      automatic logic [31:0] base = $urandom;
      if (r < 3)      ctrl = ST_SB;
      else if (r < 6) ctrl = ST_SH;
      else if (r < 9) ctrl = ST_SW;
      else            ctrl = 3'($urandom);
      if ($urandom_range(0, 1) == 0) base[1:0] = 2'b00;
      applyStimulus(1'($urandom_range(0, 3) != 0), ctrl, base, 12'($urandom), $urandom,
                    1'($urandom_range(0, 2) != 0));
      reset = ($urandom_range(0, 99) == 0);
      stepCycle();
    end
    reset = 1'b0;
    stepCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
